pacman_sprite_renderer: RTL and testbench
=========================================

# pacman_sprite_renderer

Raster stage that feeds the Pac-Man box graphic ROM and consumes its colour output. It generates 640x480@60 VGA timing from a pixel-enable tick and tracks the on-screen Pac-Man position with tear-free, frame-synchronous updates. Inside the Pac-Man box it drives box-relative coordinates to the graphic block; elsewhere it emits background colour. Its output is the final pipelined RGB with sync signals aligned to it.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths
- V_VISIBLE, 480, visible lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths
- BOX_WIDTH, 80, sprite box edge in pixels, equal to PIXELS_WIDTH
- REL_BITS, 7, relative coordinate width
- PIXEL_COLOR_BITS, 8, colour width
- BG_COLOR, 8'h00, background colour
- RESET_X / RESET_Y, 280 / 200, Pac-Man box origin after reset

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, synchronous reset, active low
- pix_en, input, 1, pixel tick; all state advances only when high
- pac_x, input, 10, requested box origin x (left edge)
- pac_y, input, 10, requested box origin y (top edge)
- pos_valid, input, 1, loads pac_x/pac_y into the shadow register
- rel_x, output, REL_BITS, x within box, to graphic block
- rel_y, output, REL_BITS, y within box, to graphic block
- box_pixel, input, PIXEL_COLOR_BITS, combinational colour returned by graphic block
- hsync, output, 1, horizontal sync, active low
- vsync, output, 1, vertical sync, active low
- rgb, output, PIXEL_COLOR_BITS, pixel colour
- frame_start, output, 1, one-clk pulse at start of vertical blanking

One clock, clk. Reset rst_n is synchronous and active-low.

## Operation
- Stage 0, counters: h counts 0..799 and wraps to 0; on wrap, v increments, wrapping 0..524. Both advance only on pix_en.
- Visible region: h<640 && v<480. hsync is low for h in [656,751]; vsync is low for v in [490,491].
- Position registers: shadow (sx,sy,pending) and active (ax,ay).
  - pos_valid loads the shadow and sets pending. Repeated loads within a frame: last wins.
  - frame_start fires on the pix_en cycle where h==0 && v==480. If pending, active <= shadow and pending clears.
  - pos_valid coincident with frame_start: the new pac_x/pac_y go straight to active, and pending stays clear.
- Box hit: h>=ax && h<ax+BOX_WIDTH && v>=ay && v<ay+BOX_WIDTH.
  - Compare at 11 bits; no wrap, so a box extending past 639/479 is clipped.
  - Origins up to 1023 are legal; an off-screen box never hits.
- Stage 1, registered on pix_en:
  - rel_x = (h-ax)[REL_BITS-1:0] and rel_y = (v-ay)[REL_BITS-1:0] when hit, else 0.
  - hit, visible, hsync_raw and vsync_raw are delayed alongside.
- Stage 2, registered on pix_en:
  - rgb = box_pixel if stage-1 visible, hit and box_pixel != 0. Black pixels are transparent.
  - rgb = BG_COLOR if stage-1 visible and not drawn.
  - rgb = 0 otherwise.
  - hsync/vsync are registered from the stage-1 copies.
- Reset values:
  - h=v=0, rel_x=rel_y=0, rgb=0, hsync=vsync=1, frame_start=0.
  - Active position = (RESET_X,RESET_Y); pending=0.
- Reset mid-frame restarts timing at h=v=0 on the next clk and discards the pending shadow.

## Timing
- rgb, hsync and vsync lag the stage-0 counter by 2 pix_en ticks, always mutually aligned.
- rel_x/rel_y lag by 1 tick. box_pixel is sampled in the same clk that rel_x/rel_y are stable.
- frame_start is a single clk wide, coincident with the pix_en cycle that matches h==0,v==480.
- With pix_en held low, every register, including outputs, holds.
- Position changes take effect for the whole next visible frame; an update never applies mid-frame.

## Structure
- Timing constants (H/V totals, porch widths), BOX_WIDTH, REL_BITS and PIXEL_COLOR_BITS belong in the shared pacman_definitions include; the graphic block uses the same values.
- One sub-module, vga_timing_counter: h/v counters, raw syncs, visible and frame_start.
- Hit test, position shadowing and the two-stage colour pipeline stay in pacman_sprite_renderer.

## Test plan
- Reset then pix_en every 4th clk: hsync period 800 ticks, low for 96; vsync period 420000 ticks, low for 1600; frame_start once per frame.
- Default position, graphic stub returning 8'h3F: stage-1 rel_x=0/rel_y=0 at h=280,v=200; rgb=8'h3F two ticks after that counter value; rgb=BG_COLOR at h=279 and h=360.
- Stub returning 0 inside the box: rgb=BG_COLOR throughout the box (transparency).
- pos_valid (100,50) at v=300 then (120,60) at v=400: frame continues at (280,200); next frame box at (120,60).
- pos_valid coincident with frame_start (10,10): next frame box at (10,10), and pending is clear afterwards.
- Origin (600,450): rel_x reaches 39 at h=639 and no hit for h>=640. Assert rst_n low mid-line: next pix_en shows h=0,v=0, rgb=0 and syncs high.

Source files
------------

// File: rtl/pacman_definitions_pkg.sv
// Shared Pac-Man raster constants and stage bundles.
// The graphic block imports the same values.
package pacman_definitions_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int PIXELS_WIDTH     = 80;
  localparam int BOX_WIDTH        = PIXELS_WIDTH;
  localparam int REL_BITS         = 7;
  localparam int PIXEL_COLOR_BITS = 8;
  localparam int CNT_BITS         = 10;

  localparam logic [PIXEL_COLOR_BITS-1:0] BG_COLOR = 8'h00;

  localparam int RESET_X = 280;
  localparam int RESET_Y = 200;

  typedef struct packed {
    logic hit;
    logic visible;
    logic hsync;
    logic vsync;
  } s1_t;

  localparam s1_t S1_RESET = '{
    hit: 1'b0, visible: 1'b0,
    hsync: 1'b1, vsync: 1'b1
  };

  // true when p lies in [lo, lo+w); 11-bit so boxes never wrap
  function automatic logic in_span(
    input logic [CNT_BITS-1:0] p,
    input logic [CNT_BITS-1:0] lo,
    input int                  w
  );
    logic [CNT_BITS:0] pp;
    logic [CNT_BITS:0] ll;
    logic [CNT_BITS:0] hh;
    pp = {1'b0, p};
    ll = {1'b0, lo};
    hh = ll + (CNT_BITS+1)'(w);
    return (pp >= ll) && (pp < hh);
  endfunction

endpackage

// File: rtl/pacman_sprite_renderer_timing.sv
// Stage 0 of the raster: h/v counters, raw syncs,
// visible flag and the frame_start strobe.
module vga_timing_counter #(
  parameter int H_VISIBLE = pacman_definitions_pkg::H_VISIBLE,
  parameter int H_FRONT   = pacman_definitions_pkg::H_FRONT,
  parameter int H_SYNC    = pacman_definitions_pkg::H_SYNC,
  parameter int H_BACK    = pacman_definitions_pkg::H_BACK,
  parameter int V_VISIBLE = pacman_definitions_pkg::V_VISIBLE,
  parameter int V_FRONT   = pacman_definitions_pkg::V_FRONT,
  parameter int V_SYNC    = pacman_definitions_pkg::V_SYNC,
  parameter int V_BACK    = pacman_definitions_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       visible,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       frame_start
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign visible     = (h < H_VIS) && (v < V_VIS);
  assign hsync_raw   = !((h >= HS_LO) && (h < HS_HI));
  assign vsync_raw   = !((v >= VS_LO) && (v < VS_HI));
  assign frame_start = pix_en && (h == '0) && (v == V_VIS);

endmodule

// File: rtl/pacman_sprite_renderer.sv
// Pac-Man raster stage: frame-synchronous box position,
// hit test and two-stage colour pipeline with aligned syncs.
module pacman_sprite_renderer
  import pacman_definitions_pkg::*;
#(
  parameter int H_VISIBLE = pacman_definitions_pkg::H_VISIBLE,
  parameter int H_FRONT   = pacman_definitions_pkg::H_FRONT,
  parameter int H_SYNC    = pacman_definitions_pkg::H_SYNC,
  parameter int H_BACK    = pacman_definitions_pkg::H_BACK,
  parameter int V_VISIBLE = pacman_definitions_pkg::V_VISIBLE,
  parameter int V_FRONT   = pacman_definitions_pkg::V_FRONT,
  parameter int V_SYNC    = pacman_definitions_pkg::V_SYNC,
  parameter int V_BACK    = pacman_definitions_pkg::V_BACK,
  parameter int BOX_WIDTH = pacman_definitions_pkg::BOX_WIDTH,
  parameter int REL_BITS  = pacman_definitions_pkg::REL_BITS,
  parameter int PIXEL_COLOR_BITS =
    pacman_definitions_pkg::PIXEL_COLOR_BITS,
  parameter logic [PIXEL_COLOR_BITS-1:0] BG_COLOR =
    pacman_definitions_pkg::BG_COLOR,
  parameter int RESET_X   = pacman_definitions_pkg::RESET_X,
  parameter int RESET_Y   = pacman_definitions_pkg::RESET_Y
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_en,
  input  logic [9:0]                  pac_x,
  input  logic [9:0]                  pac_y,
  input  logic                        pos_valid,
  output logic [REL_BITS-1:0]         rel_x,
  output logic [REL_BITS-1:0]         rel_y,
  input  logic [PIXEL_COLOR_BITS-1:0] box_pixel,
  output logic                        hsync,
  output logic                        vsync,
  output logic [PIXEL_COLOR_BITS-1:0] rgb,
  output logic                        frame_start
);

  logic [9:0] h;
  logic [9:0] v;
  logic       visible;
  logic       hsync_raw;
  logic       vsync_raw;

  vga_timing_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .h           (h),
    .v           (v),
    .visible     (visible),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .frame_start (frame_start)
  );

  logic [9:0] sx;
  logic [9:0] sy;
  logic       pending;
  logic [9:0] ax;
  logic [9:0] ay;

  // active only changes at frame_start, so no frame ever tears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sx      <= '0;
      sy      <= '0;
      pending <= 1'b0;
      ax      <= 10'(RESET_X);
      ay      <= 10'(RESET_Y);
    end else if (pix_en) begin
      if (frame_start) begin
        pending <= 1'b0;
        if (pos_valid) begin
          ax <= pac_x;
          ay <= pac_y;
        end else if (pending) begin
          ax <= sx;
          ay <= sy;
        end
      end else if (pos_valid) begin
        sx      <= pac_x;
        sy      <= pac_y;
        pending <= 1'b1;
      end
    end
  end

  logic                hit;
  logic [REL_BITS-1:0] dx;
  logic [REL_BITS-1:0] dy;

  // gating with visible clips boxes that run off the screen
  assign hit = visible
            && in_span(h, ax, BOX_WIDTH)
            && in_span(v, ay, BOX_WIDTH);
  assign dx  = REL_BITS'(h - ax);
  assign dy  = REL_BITS'(v - ay);

  s1_t s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rel_x <= '0;
      rel_y <= '0;
      s1    <= S1_RESET;
    end else if (pix_en) begin
      rel_x      <= hit ? dx : '0;
      rel_y      <= hit ? dy : '0;
      s1.hit     <= hit;
      s1.visible <= visible;
      s1.hsync   <= hsync_raw;
      s1.vsync   <= vsync_raw;
    end
  end

  logic drawn;
  assign drawn = s1.hit && (box_pixel != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      rgb   <= !s1.visible ? '0
             : drawn       ? box_pixel
             :               BG_COLOR;
      hsync <= s1.hsync;
      vsync <= s1.vsync;
    end
  end

endmodule

// File: tb/tb_pacman_sprite_renderer.sv
// Directed bench for pacman_sprite_renderer on a scaled-down
// raster (96x50 ticks) so several frames fit in a short run.
module tb_pacman_sprite_renderer;

  localparam int HV = 64, HF = 8, HS = 12, HB = 12;
  localparam int VV = 40, VF = 3, VS = 2, VB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int BW = 16, RX = 28, RY = 20;
  localparam logic [7:0] BG = 8'h12;
  localparam logic [7:0] SP = 8'h3F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       pos_valid = 1'b0;
  logic [9:0] pac_x = '0;
  logic [9:0] pac_y = '0;
  logic [6:0] rel_x;
  logic [6:0] rel_y;
  logic [7:0] box_pixel;
  logic [7:0] stub = SP;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb;
  logic       frame_start;

  assign box_pixel = stub;

  pacman_sprite_renderer #(
    .H_VISIBLE (HV), .H_FRONT (HF),
    .H_SYNC    (HS), .H_BACK  (HB),
    .V_VISIBLE (VV), .V_FRONT (VF),
    .V_SYNC    (VS), .V_BACK  (VB),
    .BOX_WIDTH (BW),
    .REL_BITS  (7),
    .PIXEL_COLOR_BITS (8),
    .BG_COLOR  (BG),
    .RESET_X   (RX), .RESET_Y (RY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .pac_x       (pac_x),
    .pac_y       (pac_y),
    .pos_valid   (pos_valid),
    .rel_x       (rel_x),
    .rel_y       (rel_y),
    .box_pixel   (box_pixel),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int mh = 0, mv = 0;
  int div = 4;
  int tick_no = 0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  int hs_falls = 0, hs_t0 = 0, hs_per = 0, hs_low = 0;
  int vs_falls = 0, vs_t0 = 0, vs_per = 0, vs_low = 0;
  int fs_between = 0, fs_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick_p(input logic pv,
                        input logic [9:0] px,
                        input logic [9:0] py);
    pos_valid = pv;
    pac_x     = px;
    pac_y     = py;
    pix_en    = 1'b1;
    #1;
    if (frame_start !== (mh == 0 && mv == VV)) fs_bad++;
    if (frame_start === 1'b1 && vs_falls == 1) fs_between++;
    @(posedge clk);
    #1;
    pix_en    = 1'b0;
    pos_valid = 1'b0;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    tick_no++;
    if (hs_prev && !hsync) begin
      hs_falls++;
      if (hs_falls == 1) hs_t0 = tick_no;
      if (hs_falls == 2) hs_per = tick_no - hs_t0;
    end
    if (!hsync && hs_falls == 1) hs_low++;
    if (vs_prev && !vsync) begin
      vs_falls++;
      if (vs_falls == 1) vs_t0 = tick_no;
      if (vs_falls == 2) vs_per = tick_no - vs_t0;
    end
    if (!vsync && vs_falls == 1) vs_low++;
    hs_prev = hsync;
    vs_prev = vsync;
    repeat (div - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    tick_p(1'b0, '0, '0);
  endtask

  task automatic run_to(input int th, input int tv);
    int n;
    n = 0;
    while (!(mh == th && mv == tv) && n < FT) begin
      tick();
      n++;
    end
    if (!(mh == th && mv == tv)) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_to(%0d,%0d): bound expired", th, tv);
    end
  endtask

  typedef struct {
    int         h;
    int         v;
    int         rx;
    int         ry;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t tv[16];

  initial begin
    // counter value now, then outputs for (h-1) and (h-2)
    tv = '{
      '{29, 20,  0,  0, BG,    1'b1, 1'b1},
      '{30, 20,  1,  0, SP,    1'b1, 1'b1},
      '{45, 20,  0,  0, SP,    1'b1, 1'b1},
      '{46, 20,  0,  0, BG,    1'b1, 1'b1},
      '{44, 35, 15, 15, SP,    1'b1, 1'b1},
      '{30, 36,  0,  0, BG,    1'b1, 1'b1},
      '{65, 36,  0,  0, BG,    1'b1, 1'b1},
      '{73, 36,  0,  0, 8'h00, 1'b1, 1'b1},
      '{74, 36,  0,  0, 8'h00, 1'b0, 1'b1},
      '{85, 36,  0,  0, 8'h00, 1'b0, 1'b1},
      '{86, 36,  0,  0, 8'h00, 1'b1, 1'b1},
      '{ 2, 39,  0,  0, BG,    1'b1, 1'b1},
      '{ 2, 40,  0,  0, 8'h00, 1'b1, 1'b1},
      '{ 2, 43,  0,  0, 8'h00, 1'b1, 1'b0},
      '{ 2, 44,  0,  0, 8'h00, 1'b1, 1'b0},
      '{ 2, 45,  0,  0, 8'h00, 1'b1, 1'b1}
    };

    repeat (3) @(posedge clk);
    #1;
    chk("reset rgb",   32'(rgb),   32'h0);
    chk("reset hsync", 32'(hsync), 32'h1);
    chk("reset vsync", 32'(vsync), 32'h1);
    chk("reset rel_x", 32'(rel_x), 32'h0);
    chk("reset rel_y", 32'(rel_y), 32'h0);
    chk("reset frame_start", 32'(frame_start), 32'h0);
    rst_n = 1'b1;
    mh = 0;
    mv = 0;

    div = 4;
    for (int i = 0; i < 16; i++) begin
      run_to(tv[i].h, tv[i].v);
      chk($sformatf("vec%0d rel_x", i), 32'(rel_x), 32'(tv[i].rx));
      chk($sformatf("vec%0d rel_y", i), 32'(rel_y), 32'(tv[i].ry));
      chk($sformatf("vec%0d rgb", i),   32'(rgb),   32'(tv[i].rgb));
      chk($sformatf("vec%0d hsync", i), 32'(hsync), 32'(tv[i].hs));
      chk($sformatf("vec%0d vsync", i), 32'(vsync), 32'(tv[i].vs));
    end

    div = 1;
    // two loads in frame 1: last wins, applied next frame
    run_to(0, 30);
    tick_p(1'b1, 10'd40, 10'd8);
    run_to(0, 35);
    tick_p(1'b1, 10'd44, 10'd6);
    run_to(30, 35);
    chk("old pos holds rgb", 32'(rgb), 32'(SP));
    run_to(0, 40);
    tick();
    run_to(46, 6);
    chk("new pos rgb",   32'(rgb),   32'(SP));
    chk("new pos rel_x", 32'(rel_x), 32'd1);
    chk("new pos rel_y", 32'(rel_y), 32'd0);

    stub = 8'h00;
    for (int x = 46; x <= 61; x++) begin
      run_to(x, 15);
      chk($sformatf("transparent h%0d", x - 2), 32'(rgb), 32'(BG));
      if (x == 50) begin
        chk("transparent rel_x", 32'(rel_x), 32'd5);
        chk("transparent rel_y", 32'(rel_y), 32'd9);
      end
    end
    stub = SP;
    run_to(30, 20);
    chk("old box gone rgb", 32'(rgb), 32'(BG));
    run_to(61, 21);
    chk("new box corner rgb", 32'(rgb),   32'(SP));
    chk("past box rel_x",     32'(rel_x), 32'd0);

    // load coincident with frame_start goes straight to active
    run_to(0, 40);
    tick_p(1'b1, 10'd10, 10'd10);
    run_to(12, 10);
    chk("coincident rgb", 32'(rgb), 32'(SP));
    run_to(30, 20);
    chk("coincident old gone", 32'(rgb), 32'(BG));
    run_to(0, 40);
    tick();
    run_to(12, 10);
    chk("pending clear rgb", 32'(rgb), 32'(SP));

    // box running off the right/bottom edge
    run_to(0, 30);
    tick_p(1'b1, 10'd60, 10'd36);
    run_to(0, 40);
    tick();
    run_to(30, 20);
    chk("clip old gone", 32'(rgb), 32'(BG));
    run_to(64, 36);
    chk("clip last rel_x", 32'(rel_x), 32'd3);
    chk("clip last rel_y", 32'(rel_y), 32'd0);
    chk("clip last rgb",   32'(rgb),   32'(SP));
    run_to(65, 36);
    chk("clip off rel_x", 32'(rel_x), 32'd0);
    run_to(66, 36);
    chk("clip off rgb", 32'(rgb), 32'h0);

    // reset mid-line with a pending load outstanding
    run_to(50, 37);
    tick_p(1'b1, 10'd5, 10'd5);
    rst_n  = 1'b0;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    rst_n  = 1'b1;
    mh = 0;
    mv = 0;
    chk("midreset rgb",   32'(rgb),   32'h0);
    chk("midreset hsync", 32'(hsync), 32'h1);
    chk("midreset vsync", 32'(vsync), 32'h1);
    chk("midreset rel_x", 32'(rel_x), 32'h0);
    run_to(30, 20);
    chk("post reset rgb",   32'(rgb),   32'(SP));
    chk("post reset rel_x", 32'(rel_x), 32'd1);
    run_to(0, 40);
    tick();
    run_to(30, 20);
    chk("pending dropped rgb", 32'(rgb), 32'(SP));

    chk("hsync period",    32'(hs_per),     32'(HT));
    chk("hsync low ticks", 32'(hs_low),     32'(HS));
    chk("vsync period",    32'(vs_per),     32'(FT));
    chk("vsync low ticks", 32'(vs_low),     32'(VS * HT));
    chk("frame_start per frame", 32'(fs_between), 32'd1);
    chk("frame_start timing",    32'(fs_bad),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
